icache_controller: RTL and testbench

Direct-mapped, read-only instruction cache. It answers fetch requests from the PC/fetch stage and refills 16-byte blocks from instruction memory over a busywait handshake. It sits between pc_unit and instruction memory. The CPU stalls PC update while BUSYWAIT is high.

---
 rtl/icache_pkg.sv | 33 +++
 rtl/icache_if.sv | 25 ++
 rtl/icache_word_select.sv | 21 ++
 rtl/icache_controller.sv | 98 +++++++++
 tb/tb_icache_controller.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and field layout for the direct-mapped instruction cache.
// PC_ADDR = {tag, index, word offset, byte offset}; blocks are 4 words.
package icache_pkg;

   localparam int ADDR_W  = 10;
   localparam int INDEX_W = 3;
   localparam int OFF_LSB = 2;
   localparam int OFF_W   = 2;
   localparam int BLK_LSB = 4;
   localparam int TAG_W   = ADDR_W - INDEX_W - BLK_LSB;
   localparam int LINES   = 2 ** INDEX_W;
   localparam int BLOCK_W = 128;
   localparam int BADDR_W = TAG_W + INDEX_W;

   typedef enum logic [1:0] {
      IDLE,
      MEM_FETCH,
      UPDATE
   } state_t;

   function automatic logic [INDEX_W-1:0] index_of(
      input logic [ADDR_W-1:0] a
   );
      return a[BLK_LSB +: INDEX_W];
   endfunction

   function automatic logic [TAG_W-1:0] tag_of(
      input logic [ADDR_W-1:0] a
   );
      return a[ADDR_W-1 -: TAG_W];
   endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side bus of the instruction cache.
// slave = the cache, master = fetch stage plus instruction memory.
interface icache_if;
   import icache_pkg::*;

   logic                READ;
   logic [ADDR_W-1:0]   PC_ADDR;
   logic [31:0]         INSTRUCTION;
   logic                BUSYWAIT;
   logic                MEM_READ;
   logic [BADDR_W-1:0]  MEM_ADDRESS;
   logic [BLOCK_W-1:0]  MEM_READDATA;
   logic                MEM_BUSYWAIT;

   modport slave (
      input  READ, PC_ADDR, MEM_READDATA, MEM_BUSYWAIT,
      output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
   );

   modport master (
      output READ, PC_ADDR, MEM_READDATA, MEM_BUSYWAIT,
      input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS
   );

endinterface

// File: rtl/icache_word_select.sv
// Picks one 32-bit instruction out of a 128-bit cache block.
module icache_word_select
   import icache_pkg::*;
(
   input  logic [BLOCK_W-1:0] block,
   input  logic [OFF_W-1:0]   off,
   output logic [31:0]        word
);

   always_comb begin
      word = '0;
      unique case (off)
         2'd0: word = block[31:0];
         2'd1: word = block[63:32];
         2'd2: word = block[95:64];
         2'd3: word = block[127:96];
         default: word = '0;
      endcase
   end

endmodule

// File: rtl/icache_controller.sv
// Direct-mapped read-only instruction cache with 16-byte block refill.
module icache_controller
   import icache_pkg::*;
(
   input logic       CLK,
   input logic       RESET,
   icache_if.slave   bus
);

   state_t              state_q, state_d;
   logic [LINES-1:0]    valid_q;
   logic [TAG_W-1:0]    tag_q  [LINES];
   logic [BLOCK_W-1:0]  data_q [LINES];
   logic [BADDR_W-1:0]  fill_q;
   logic [BLOCK_W-1:0]  fill_data_q;

   logic [INDEX_W-1:0]  idx;
   logic [TAG_W-1:0]    tag;
   logic [INDEX_W-1:0]  fill_idx;
   logic                hit;
   logic [31:0]         word;

   logic                busy;
   logic                mem_read;
   logic [BADDR_W-1:0]  mem_addr;
   logic [31:0]         instr;

   assign idx      = index_of(bus.PC_ADDR);
   assign tag      = tag_of(bus.PC_ADDR);
   assign fill_idx = fill_q[INDEX_W-1:0];
   assign hit      = bus.READ && valid_q[idx] && (tag_q[idx] == tag);

   icache_word_select u_sel (
      .block (data_q[idx]),
      .off   (bus.PC_ADDR[OFF_LSB +: OFF_W]),
      .word  (word)
   );

   always_comb begin
      state_d  = state_q;
      busy     = 1'b0;
      mem_read = 1'b0;
      mem_addr = '0;
      instr    = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.READ && !hit) begin
               busy    = 1'b1;
               state_d = MEM_FETCH;
            end else if (hit) begin
               instr = word;
            end
         end
         MEM_FETCH: begin
            busy     = 1'b1;
            mem_read = 1'b1;
            mem_addr = fill_q;
            if (!bus.MEM_BUSYWAIT)
               state_d = UPDATE;
         end
         UPDATE: begin
            busy    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         valid_q <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && bus.READ && !hit)
            fill_q <= {tag, idx};
         if (state_q == UPDATE)
            valid_q[fill_idx] <= 1'b1;
      end
   end

   // Tag/data arrays carry no reset; valid_q alone gates their use.
   always_ff @(posedge CLK) begin
      if (state_q == MEM_FETCH && !bus.MEM_BUSYWAIT)
         fill_data_q <= bus.MEM_READDATA;
      if (state_q == UPDATE) begin
         data_q[fill_idx] <= fill_data_q;
         tag_q[fill_idx]  <= fill_q[BADDR_W-1 -: TAG_W];
      end
   end

   assign bus.BUSYWAIT    = busy;
   assign bus.MEM_READ    = mem_read;
   assign bus.MEM_ADDRESS = mem_addr;
   assign bus.INSTRUCTION = instr;

endmodule

// File: tb/tb_icache_controller.sv
// Scoreboard bench for icache_controller: random fetches against a
// line-occupancy model of the cache and a behavioural memory.
module tb_icache_controller;

   logic CLK;
   logic RESET;
   icache_if bus ();

   icache_controller dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   int n_cmp = 0;
   int n_bad = 0;

   logic [127:0] mem [64];
   bit           m_valid [8];
   int           m_blk [8];
   logic [31:0]  exp_q [$];
   logic [5:0]   miss_q [$];
   int           next_lat = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic bad(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s", nm);
   endtask

   function automatic logic [31:0] mword(input logic [5:0] b,
                                         input logic [1:0] o);
      logic [127:0] t;
      t = mem[b] >> (32 * o);
      return t[31:0];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_valid[i] = 0;
   endtask

   // Instruction monitor: pops one expectation per completed fetch.
   always @(negedge CLK) begin
      if (!RESET && bus.READ && !bus.BUSYWAIT) begin
         if (exp_q.size() == 0) bad("instr_unexpected");
         else chk("instr", bus.INSTRUCTION, exp_q.pop_front());
      end
   end

   // Instruction memory: checks each block request, answers after next_lat.
   initial begin
      bit         act;
      int         cnt;
      logic [5:0] addr;
      act = 0; cnt = 0; addr = '0;
      bus.MEM_BUSYWAIT = 1'b1;
      bus.MEM_READDATA = '0;
      forever begin
         @(negedge CLK);
         if (RESET || !bus.MEM_READ) begin
            act = 0;
            bus.MEM_BUSYWAIT = 1'b1;
         end else begin
            if (!act) begin
               act  = 1;
               cnt  = next_lat;
               addr = bus.MEM_ADDRESS;
               if (miss_q.size() == 0) bad("mem_read_unexpected");
               else chk("mem_address", addr, miss_q.pop_front());
            end else begin
               chk("mem_address_stable", bus.MEM_ADDRESS, addr);
               if (cnt > 0) cnt--;
            end
            bus.MEM_BUSYWAIT = (cnt != 0);
            bus.MEM_READDATA = (cnt == 0) ? mem[addr]
               : {$urandom, $urandom, $urandom, $urandom};
         end
      end
   end

   task automatic fetch(input logic [9:0] a, input int lat);
      logic [5:0] blk;
      int         idx;
      bit         miss;
      int         busy;
      bit         done;
      blk  = a[9:4];
      idx  = int'(a[6:4]);
      miss = !(m_valid[idx] && m_blk[idx] == int'(blk));
      exp_q.push_back(mword(blk, a[3:2]));
      if (miss) begin
         miss_q.push_back(blk);
         m_valid[idx] = 1;
         m_blk[idx]   = int'(blk);
      end
      next_lat    = lat;
      bus.READ    = 1'b1;
      bus.PC_ADDR = a;
      #1 chk("busywait_initial", bus.BUSYWAIT, miss);
      busy = 0;
      done = 0;
      while (!done && busy < 40) begin
         @(negedge CLK);
         if (bus.BUSYWAIT) busy++;
         else done = 1;
      end
      if (!done) bad("fetch_timeout");
      else chk("stall_cycles", busy, miss ? lat + 3 : 0);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [9:0] a;
      bit         seen;
      RESET       = 1'b1;
      bus.READ    = 1'b0;
      bus.PC_ADDR = '0;
      for (int i = 0; i < 64; i++)
         mem[i] = {$urandom, $urandom, $urandom, $urandom};
      mem[0] = 128'h00000004_00000003_00000002_00000001;
      mem[8][31:0] = 32'hDEADBEEF;
      model_clear();

      #2;
      chk("rst_busywait", bus.BUSYWAIT, 1'b0);
      chk("rst_mem_read", bus.MEM_READ, 1'b0);
      chk("rst_mem_address", bus.MEM_ADDRESS, 6'h00);
      chk("rst_instruction", bus.INSTRUCTION, 32'h0);
      @(posedge CLK);
      @(posedge CLK);
      #1 RESET = 1'b0;

      fetch(10'h000, 4);
      fetch(10'h004, 0);
      fetch(10'h00C, 0);
      fetch(10'h080, 2);
      fetch(10'h000, 1);

      // Asynchronous reset pulse between clock edges.
      bus.READ    = 1'b1;
      bus.PC_ADDR = 10'h000;
      #1 chk("pre_pulse_hit", bus.INSTRUCTION, 32'h00000001);
      RESET = 1'b1;
      #1;
      chk("pulse_instruction", bus.INSTRUCTION, 32'h0);
      chk("pulse_mem_read", bus.MEM_READ, 1'b0);
      bus.READ = 1'b0;
      #1 chk("pulse_busywait", bus.BUSYWAIT, 1'b0);
      RESET = 1'b0;
      model_clear();
      @(posedge CLK);
      #1;
      fetch(10'h008, 0);
      fetch(10'h080, 3);

      // Reset in the middle of a refill.
      miss_q.push_back(6'h00);
      next_lat    = 20;
      bus.READ    = 1'b1;
      bus.PC_ADDR = 10'h000;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge CLK);
         seen = bus.MEM_READ;
      end
      if (!seen) bad("midfill_no_mem_read");
      @(negedge CLK);
      #2 RESET = 1'b1;
      #1;
      chk("midfill_mem_read", bus.MEM_READ, 1'b0);
      chk("midfill_busywait", bus.BUSYWAIT, 1'b1);
      RESET    = 1'b0;
      bus.READ = 1'b0;
      model_clear();
      @(posedge CLK);
      #1;
      fetch(10'h000, 2);

      // Uncached address with READ low never starts a fill.
      bus.READ    = 1'b0;
      bus.PC_ADDR = 10'h3F0;
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("noread_busywait", bus.BUSYWAIT, 1'b0);
         chk("noread_mem_read", bus.MEM_READ, 1'b0);
      end
      @(posedge CLK);
      #1;

      for (int n = 0; n < 80; n++) begin
         a = {3'($urandom_range(0, 2)), 3'($urandom),
              2'($urandom), 2'b00};
         fetch(a, $urandom_range(0, 4));
         if ($urandom_range(0, 3) == 0) begin
            bus.READ = 1'b0;
            @(posedge CLK);
            #1;
         end
      end

      bus.READ = 1'b0;
      repeat (3) @(posedge CLK);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("miss_q_drained", miss_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
